alu_seq: RTL

Parametrised, pipelined ALU with valid/ready handshakes on operand input and result output. It replaces the combinational 2-bit ALU in the datapath. It executes the same operation set at any width, adds rotate-left, and computes MODULO with an iterative multi-cycle unit. Results and flags are registered and held until the consumer accepts them.

---
 rtl/alu_seq_pkg.sv | 28 ++
 rtl/alu_mod_unit.sv | 67 ++++++
 rtl/alu_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode map, control state encoding and default widths shared
// by the sequential ALU and its iterative modulo unit.
package alu_seq_pkg;

    localparam int SEL_WIDTH = 4;
    localparam int ARG_WIDTH = 8;

    localparam logic [SEL_WIDTH-1:0] OP_ADD  = 4'd0;
    localparam logic [SEL_WIDTH-1:0] OP_SUB  = 4'd1;
    localparam logic [SEL_WIDTH-1:0] OP_AND  = 4'd2;
    localparam logic [SEL_WIDTH-1:0] OP_OR   = 4'd3;
    localparam logic [SEL_WIDTH-1:0] OP_XOR  = 4'd4;
    localparam logic [SEL_WIDTH-1:0] OP_NOR  = 4'd5;
    localparam logic [SEL_WIDTH-1:0] OP_NAND = 4'd6;
    localparam logic [SEL_WIDTH-1:0] OP_XNOR = 4'd7;
    localparam logic [SEL_WIDTH-1:0] OP_MOD  = 4'd8;
    localparam logic [SEL_WIDTH-1:0] OP_EQU  = 4'd9;
    localparam logic [SEL_WIDTH-1:0] OP_GT   = 4'd10;
    localparam logic [SEL_WIDTH-1:0] OP_LT   = 4'd11;
    localparam logic [SEL_WIDTH-1:0] OP_ROR  = 4'd12;
    localparam logic [SEL_WIDTH-1:0] OP_ROL  = 4'd13;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mod_unit.sv
// alu_mod_unit: restoring-remainder modulo, one quotient bit per cycle.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   start       - capture a/b and begin WIDTH iterations
//   a, b        - dividend / divisor (b must be non-zero)
//   busy        - iterations remaining
//   done        - rem holds the finished remainder (held until next start)
//   rem         - remainder
module alu_mod_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rem
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic             done_q;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   trial_sub;

    // rem_q < dvs_q always holds, so the shifted trial fits in WIDTH+1 bits
    assign trial     = {rem_q, dvd_q[WIDTH-1]};
    assign trial_sub = trial - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            cnt_q  <= CNT_W'(WIDTH);
            rem_q  <= '0;
            dvd_q  <= a;
            dvs_q  <= b;
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            if (trial >= {1'b0, dvs_q}) begin
                rem_q <= trial_sub[WIDTH-1:0];
            end else begin
                rem_q <= trial[WIDTH-1:0];
            end
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                done_q <= 1'b1;
            end
        end
    end

    assign busy = (cnt_q != '0);
    assign done = done_q;
    assign rem  = rem_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: pipelined ALU with valid/ready on operands and result. Single-cycle
// ops load the result register directly; MOD with b!=0 iterates in
// alu_mod_unit. Result and flags are held until the consumer accepts them.
// Ports:
//   clk, rst_n             - clock, async active-low reset
//   in_valid/in_ready      - operand beat handshake (a, b, sel)
//   out_valid/out_ready    - result handshake (out, zero, carry, overflow, error)
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | accepting beats; non-iterative ops load the result register
// ST_BUSY | modulo iterating; loads result once done and output is free
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ARG_WIDTH,
    parameter int OP_W  = SEL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             error
);

    localparam logic [WIDTH-1:0] W_L = WIDTH'(WIDTH);

    state_t state_q, state_d;

    logic [WIDTH:0]       sum_ext, diff_ext;
    logic [WIDTH-1:0]     rot_amt;
    logic [2*WIDTH-1:0]   rol_ext, ror_ext;
    logic [WIDTH-1:0]     res;
    logic                 res_c, res_v, res_err, op_valid, op_iter;

    logic                 out_free, accept;
    logic                 mod_start, load_single, load_mod;
    logic                 mod_busy, mod_done;
    logic [WIDTH-1:0]     mod_rem;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign rot_amt  = b % W_L;
    assign rol_ext  = {a, a} << rot_amt;
    assign ror_ext  = {a, a} >> rot_amt;

    // An X/Z or unused opcode matches no item and falls to the invalid default.
    always_comb begin
        res      = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        res_err  = 1'b0;
        op_valid = 1'b1;
        op_iter  = 1'b0;
        case (sel)
            OP_ADD: begin
                res   = sum_ext[WIDTH-1:0];
                res_c = sum_ext[WIDTH];
                res_v = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff_ext[WIDTH-1:0];
                res_c = (a < b);
                res_v = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_NAND: res = ~(a & b);
            OP_XNOR: res = ~(a ^ b);
            OP_MOD: begin
                if (b == '0) begin
                    res     = a;
                    res_err = 1'b1;
                end else begin
                    op_iter = 1'b1;
                end
            end
            OP_EQU:  res = {{(WIDTH-1){1'b0}}, a == b};
            OP_GT:   res = {{(WIDTH-1){1'b0}}, a > b};
            OP_LT:   res = {{(WIDTH-1){1'b0}}, a < b};
            OP_ROR:  res = ror_ext[WIDTH-1:0];
            OP_ROL:  res = rol_ext[2*WIDTH-1:WIDTH];
            default: begin
                res_err  = 1'b1;
                op_valid = 1'b0;
            end
        endcase
    end

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state_q == ST_IDLE) && !mod_busy && out_free;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mod_start   = 1'b0;
        load_single = 1'b0;
        load_mod    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (op_iter) begin
                        mod_start = 1'b1;
                        state_d   = ST_BUSY;
                    end else begin
                        load_single = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                // a finished remainder waits here while an older result stalls
                if (mod_done && out_free) begin
                    load_mod = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            error     <= 1'b0;
        end else if (load_single) begin
            out_valid <= 1'b1;
            out       <= res;
            zero      <= op_valid && (res == '0);
            carry     <= res_c;
            overflow  <= res_v;
            error     <= res_err;
        end else if (load_mod) begin
            out_valid <= 1'b1;
            out       <= mod_rem;
            zero      <= (mod_rem == '0);
            carry     <= 1'b0;
            overflow  <= 1'b0;
            error     <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    alu_mod_unit #(.WIDTH(WIDTH)) u_mod (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mod_start),
        .a     (a),
        .b     (b),
        .busy  (mod_busy),
        .done  (mod_done),
        .rem   (mod_rem)
    );

endmodule
